// File: rtl/board_dbg_pkg.sv
// board_dbg_pkg: shared constants and helpers for the board debug controller.
//   hex_to_seg : 4-bit nibble -> active-low {dp,g,f,e,d,c,b,a}, dp off
//   sel_width  : width of the display channel select bus
//   NDIG       : number of multiplexed display digits
//   SEG_BLANK  : all segments off
package board_dbg_pkg;

    localparam int unsigned NDIG = 8;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Four bits cover up to 15 probe channels plus the step counter slot.
    function automatic int unsigned sel_width();
        return 4;
    endfunction

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] seg;
        unique case (nib)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            4'hF: seg = 8'h8E;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/board_debug_ctrl_if.sv
// board_debug_ctrl_if: board-pin / CPU-side signal bundle of the debug controller.
//   run_mode, step_btn, hold : board switches/button (asynchronous)
//   sel                      : display channel select
//   probe_bus                : NCH probe channels of DW bits, channel k at [k*DW +: DW]
//   cpu_ce, step_cnt         : CPU clock enable and executed-step count
//   o_seg, o_sel             : active-low seven-segment segments and digit enables
// slave = controller side, master = board/core side.
interface board_debug_ctrl_if #(
    parameter int unsigned NCH = 4,
    parameter int unsigned DW  = 32
) ();
    import board_dbg_pkg::*;

    localparam int unsigned SEL_W = sel_width();

    logic                run_mode;
    logic                step_btn;
    logic                hold;
    logic [SEL_W-1:0]    sel;
    logic [NCH*DW-1:0]   probe_bus;
    logic                cpu_ce;
    logic [31:0]         step_cnt;
    logic [7:0]          o_seg;
    logic [7:0]          o_sel;

    modport slave (
        input  run_mode, step_btn, hold, sel, probe_bus,
        output cpu_ce, step_cnt, o_seg, o_sel
    );

    modport master (
        output run_mode, step_btn, hold, sel, probe_bus,
        input  cpu_ce, step_cnt, o_seg, o_sel
    );

endinterface

// File: rtl/board_debounce.sv
// board_debounce: 2-flop synchroniser plus stability counter for a push button.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_btn          : raw asynchronous button level
//   o_level        : debounced level
//   o_rise         : one-cycle pulse when the debounced level is accepted as 1
// A button held through reset must be released (debounced low) before a
// rise is reported, so reset never manufactures a step.
module board_debounce #(
    parameter int unsigned DEB_CYC = 1000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise
);

    localparam int unsigned DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    logic [1:0]       r_sync;
    logic [1:0]       r_vld;
    logic [DEB_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;
    logic             r_armed;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync  <= 2'b00;
            r_vld   <= 2'b00;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_btn};
            // r_vld[1] marks that r_sync[1] holds a real sample, not the reset value.
            r_vld  <= {r_vld[0], 1'b1};
            r_rise <= 1'b0;
            if (r_vld[1] && !r_sync[1] && !r_level) begin
                r_armed <= 1'b1;
            end
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == DEB_W'(DEB_CYC - 1)) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
                r_rise  <= r_sync[1] & r_armed;
            end else begin
                r_cnt <= r_cnt + DEB_W'(1);
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;

endmodule

// File: rtl/board_debug_ctrl.sv
// board_debug_ctrl: board-level debug controller for the minimal SoPC board.
//   clk_in : board clock (single domain)
//   reset  : synchronous active-low reset
//   bus    : board_debug_ctrl_if.slave (switches, button, probes, cpu_ce,
//            step_cnt, seven-segment outputs)
// Generates a one-cycle CPU clock enable (free-run tick or debounced step),
// counts steps, muxes a probe channel or the step counter into a freezable
// display register and scans it as 8 hex digits.
module board_debug_ctrl
    import board_dbg_pkg::*;
#(
    parameter int unsigned NCH      = 4,
    parameter int unsigned DW       = 32,
    parameter int unsigned DIV      = 100000,
    parameter int unsigned DEB_CYC  = 1000000,
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic               clk_in,
    input  logic               reset,
    board_debug_ctrl_if.slave  bus
);

    localparam int unsigned SEL_W  = sel_width();
    localparam int unsigned TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [1:0]        r_run_s;
    logic [1:0]        r_hold_s;
    logic [TICK_W-1:0] r_tick_cnt;
    logic              r_cpu_ce;
    logic [31:0]       r_step_cnt;
    logic [31:0]       r_disp;
    logic [SCAN_W-1:0] r_scan_cnt;
    logic [2:0]        r_dig;
    logic [7:0]        r_o_sel;
    logic [7:0]        r_o_seg;

    logic              w_tick;
    logic              w_scan_wrap;
    logic              w_step_req;
    logic              w_deb_level;
    logic [31:0]       w_src;

    board_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_step_deb (
        .i_clk   (clk_in),
        .i_rst_n (reset),
        .i_btn   (bus.step_btn),
        .o_level (w_deb_level),
        .o_rise  (w_step_req)
    );

    assign w_tick      = (r_tick_cnt == TICK_W'(DIV - 1));
    assign w_scan_wrap = (r_scan_cnt == SCAN_W'(SCAN_DIV - 1));

    // Source select; sel above NCH shows 0. step_cnt here is the
    // pre-increment value when cpu_ce is high in the same cycle.
    always_comb begin
        w_src = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (bus.sel == SEL_W'(k)) begin
                w_src = 32'(bus.probe_bus[k*DW +: DW]);
            end
        end
        if (bus.sel == SEL_W'(NCH)) begin
            w_src = r_step_cnt;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            r_run_s    <= 2'b00;
            r_hold_s   <= 2'b00;
            r_tick_cnt <= '0;
            r_cpu_ce   <= 1'b0;
            r_step_cnt <= '0;
            r_disp     <= '0;
            r_scan_cnt <= '0;
            r_dig      <= 3'd0;
            r_o_sel    <= SEG_BLANK;
            r_o_seg    <= SEG_BLANK;
        end else begin
            r_run_s    <= {r_run_s[0], bus.run_mode};
            r_hold_s   <= {r_hold_s[0], bus.hold};
            // Tick phase is free-running and unaffected by the mode switch.
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TICK_W'(1);
            r_cpu_ce   <= r_run_s[1] ? w_tick : w_step_req;
            r_step_cnt <= r_step_cnt + 32'(r_cpu_ce);
            if (!r_hold_s[1]) begin
                r_disp <= w_src;
            end
            r_scan_cnt <= w_scan_wrap ? '0 : r_scan_cnt + SCAN_W'(1);
            if (w_scan_wrap) begin
                r_dig <= r_dig + 3'd1;
            end
            r_o_sel <= ~(8'b1 << r_dig);
            r_o_seg <= hex_to_seg(r_disp[{r_dig, 2'b00} +: 4]);
        end
    end

    assign bus.cpu_ce   = r_cpu_ce;
    assign bus.step_cnt = r_step_cnt;
    assign bus.o_sel    = r_o_sel;
    assign bus.o_seg    = r_o_seg;

endmodule

// File: tb/tb_board_debug_ctrl.sv
// tb_board_debug_ctrl: directed self-checking bench for board_debug_ctrl
// with NCH=4, DW=32, DIV=4, DEB_CYC=3, SCAN_DIV=2.
module tb_board_debug_ctrl;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    // Active-low segment patterns for 0..F, written out independently of the RTL.
    localparam logic [7:0] SEG_TAB [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    board_debug_ctrl_if #(.NCH(4), .DW(32)) dbg ();

    board_debug_ctrl #(
        .NCH      (4),
        .DW       (32),
        .DIV      (4),
        .DEB_CYC  (3),
        .SCAN_DIV (2)
    ) dut (
        .clk_in (clk),
        .reset  (rst_n),
        .bus    (dbg.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not reach its end");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < n; i++) step_clk();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        wait_cyc(2);
        rst_n = 1'b1;
    endtask

    // Reassemble the displayed 32-bit value from the scanned digits.
    task automatic read_disp(output logic [31:0] val);
        logic [7:0] seen;
        val  = 'x;
        seen = '0;
        for (int c = 0; c < 40 && seen != 8'hFF; c++) begin
            step_clk();
            for (int d = 0; d < 8; d++) begin
                if (dbg.o_sel == 8'(~(8'h01 << d))) begin
                    for (int n = 0; n < 16; n++) begin
                        if (dbg.o_seg == SEG_TAB[n]) begin
                            val[4*d +: 4] = 4'(n);
                            seen[d] = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        logic [31:0] v;
        logic [7:0]  prev;
        int          pulses;
        bit          found;

        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        dbg.run_mode  = 1'b1;
        dbg.step_btn  = 1'b0;
        dbg.hold      = 1'b0;
        dbg.sel       = 4'd0;
        dbg.probe_bus = '0;

        // Reset state and free run.
        wait_cyc(2);
        check_eq("rst_o_sel", 32'(dbg.o_sel), 32'hFF);
        check_eq("rst_o_seg", 32'(dbg.o_seg), 32'hFF);
        check_eq("rst_step_cnt", dbg.step_cnt, 32'd0);
        check_eq("rst_cpu_ce", 32'(dbg.cpu_ce), 32'd0);
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step_clk();
            if (k == 1) begin
                check_eq("first_o_sel", 32'(dbg.o_sel), 32'hFE);
                check_eq("first_o_seg", 32'(dbg.o_seg), 32'hC0);
            end
            check_eq("freerun_ce", 32'(dbg.cpu_ce), 32'((k % 4) == 0));
        end
        dbg.run_mode = 1'b0;
        step_clk();
        check_eq("freerun_cnt", dbg.step_cnt, 32'd3);

        // Step mode with no button: no pulses.
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            step_clk();
            pulses += int'(dbg.cpu_ce);
        end
        check_eq("stepmode_idle_ce", 32'(pulses), 32'd0);
        check_eq("stepmode_idle_cnt", dbg.step_cnt, 32'd3);

        // Step with bounce: 1,0,1 then held.
        apply_reset();
        wait_cyc(5);
        dbg.step_btn = 1'b1;
        step_clk();
        dbg.step_btn = 1'b0;
        step_clk();
        dbg.step_btn = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step_clk();
            check_eq("bounce_ce", 32'(dbg.cpu_ce), 32'(k == 6));
        end
        check_eq("bounce_cnt", dbg.step_cnt, 32'd1);
        dbg.step_btn = 1'b0;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            step_clk();
            pulses += int'(dbg.cpu_ce);
        end
        check_eq("release_ce", 32'(pulses), 32'd0);
        check_eq("release_cnt", dbg.step_cnt, 32'd1);

        // Mux and hold (step_cnt stays at 1 in step mode).
        dbg.probe_bus[2*32 +: 32] = 32'h12345678;
        dbg.probe_bus[1*32 +: 32] = 32'hCAFEF00D;
        dbg.sel = 4'd2;
        wait_cyc(4);
        read_disp(v);
        check_eq("mux_ch2", v, 32'h12345678);
        dbg.hold = 1'b1;
        wait_cyc(4);
        dbg.probe_bus[2*32 +: 32] = 32'h0;
        wait_cyc(4);
        read_disp(v);
        check_eq("hold_ch2", v, 32'h12345678);
        dbg.hold = 1'b0;
        dbg.sel  = 4'd1;
        wait_cyc(4);
        read_disp(v);
        check_eq("mux_ch1", v, 32'hCAFEF00D);
        dbg.sel = 4'd4;
        wait_cyc(4);
        read_disp(v);
        check_eq("mux_stepcnt", v, 32'd1);
        dbg.sel = 4'd7;
        wait_cyc(4);
        read_disp(v);
        check_eq("mux_oob", v, 32'd0);

        // Scan order and timing with disp = 0x0000000A.
        dbg.probe_bus[0 +: 32] = 32'h0000000A;
        dbg.sel = 4'd0;
        wait_cyc(4);
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            prev = dbg.o_sel;
            step_clk();
            if (dbg.o_sel == 8'hFE && prev != 8'hFE) found = 1'b1;
        end
        check_eq("scan_sync", 32'(found), 32'd1);
        for (int d = 0; d < 8; d++) begin
            for (int c = 0; c < 2; c++) begin
                if (d != 0 || c != 0) step_clk();
                check_eq("scan_o_sel", 32'(dbg.o_sel), 32'(8'(~(8'h01 << d))));
                check_eq("scan_o_seg", 32'(dbg.o_seg), (d == 0) ? 32'h88 : 32'hC0);
            end
        end

        // Run mode: button presses add nothing beyond the tick rate.
        dbg.run_mode = 1'b1;
        apply_reset();
        wait_cyc(8);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            dbg.step_btn = ((k % 10) < 5);
            step_clk();
            pulses += int'(dbg.cpu_ce);
        end
        check_eq("runmode_btn_ce", 32'(pulses), 32'd10);
        dbg.step_btn = 1'b0;

        // Reset during a debounce count and mid-scan, button held through it.
        dbg.run_mode = 1'b0;
        wait_cyc(10);
        dbg.step_btn = 1'b1;
        wait_cyc(3);
        rst_n = 1'b0;
        step_clk();
        check_eq("midrst_o_sel", 32'(dbg.o_sel), 32'hFF);
        check_eq("midrst_o_seg", 32'(dbg.o_seg), 32'hFF);
        check_eq("midrst_step_cnt", dbg.step_cnt, 32'd0);
        check_eq("midrst_cpu_ce", 32'(dbg.cpu_ce), 32'd0);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            step_clk();
            pulses += int'(dbg.cpu_ce);
        end
        check_eq("held_btn_ce", 32'(pulses), 32'd0);
        dbg.step_btn = 1'b0;
        wait_cyc(10);
        dbg.step_btn = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step_clk();
            check_eq("repress_ce", 32'(dbg.cpu_ce), 32'(k == 6));
        end
        check_eq("repress_cnt", dbg.step_cnt, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
